jt7759_host: RTL and testbench

Slave-mode data source for the JT7759 passive interface. Once started, it streams a block of ADPCM bytes from its own memory port into the sound chip, writing one byte per falling edge of the chip's `drqn` request and driving the `cs`/`wrn`/`din` bus that the chip's data fetcher samples when `mdn=0`. It sits on the host side of the chip and serves both as the host-CPU helper in cores that run the chip in slave mode and as the stimulus driver in slave-mode simulations.

---
 rtl/jt7759_pkg.sv | 5 +
 rtl/jt7759_strobe.sv | 32 +++
 rtl/jt7759_host.sv | 103 ++++++++++
 tb/tb_jt7759_host.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt7759_pkg.sv
// jt7759_pkg: shared state encoding and defaults for the JT7759 slave-mode host streamer
package jt7759_pkg;
    typedef enum logic [1:0] {IDLE, RUN, WRITE, DONE} state_t;
    localparam int WR_W_DEF = 4;
endpackage

// File: rtl/jt7759_strobe.sv
// jt7759_strobe: holds the chip write strobe for WR_W cen_ctl ticks after a trigger
module jt7759_strobe import jt7759_pkg::*; #(
    parameter int WR_W = WR_W_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic cen_ctl,
    input  logic trig,
    input  logic clr,
    output logic active,
    output logic last
);
    logic [3:0] cnt;

    assign last = active & cen_ctl & (cnt == 4'(WR_W - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (clr) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (trig) begin
            active <= 1'b1;
            cnt    <= '0;
        end else if (active && cen_ctl) begin
            cnt <= cnt + 4'd1;
            if (last) active <= 1'b0;
        end
    end
endmodule

// File: rtl/jt7759_host.sv
// jt7759_host: streams a memory block into the JT7759 passive bus, one byte per drqn request
module jt7759_host import jt7759_pkg::*; #(
    parameter int AW   = 17,
    parameter int WR_W = WR_W_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cen_ctl,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] length,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          rom_cs,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    input  logic          drqn,
    output logic          cs,
    output logic          wrn,
    output logic [7:0]    dout
);
    state_t        state, next;
    logic [AW-1:0] cnt;
    logic [7:0]    buffer;
    logic          valid, pend, drqn_l, fall, fetch, go, active, last;

    assign fall   = drqn_l & ~drqn;
    assign rom_cs = (state == RUN) & ~valid & (cnt != '0);
    assign fetch  = rom_cs & rom_ok;
    // a byte arriving in the same cycle as a pending request goes straight to the bus
    assign go     = (state == RUN) & pend & (valid | fetch);
    assign busy   = state != IDLE;
    assign cs     = active;
    assign wrn    = ~active;

    jt7759_strobe #(.WR_W(WR_W)) u_strobe (
        .clk    (clk),
        .rstn   (rstn),
        .cen_ctl(cen_ctl),
        .trig   (go),
        .clr    (abort),
        .active (active),
        .last   (last)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = (start && length != '0) ? RUN : IDLE;
            RUN:     next = go ? WRITE : RUN;
            WRITE:   next = last ? ((cnt == AW'(1)) ? DONE : RUN) : WRITE;
            default: next = IDLE;
        endcase
        if (abort) next = IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done     <= 1'b0;
            rom_addr <= '0;
            cnt      <= '0;
            buffer   <= '0;
            valid    <= 1'b0;
            pend     <= 1'b0;
            drqn_l   <= 1'b1;
            dout     <= '0;
        end else begin
            drqn_l <= drqn;
            done   <= ~abort & ((state == DONE) | ((state == IDLE) & start & (length == '0)));
            if (abort) begin
                valid <= 1'b0;
                pend  <= 1'b0;
            end else begin
                if (state == IDLE) begin
                    pend <= 1'b0;
                    if (start && length != '0) begin
                        rom_addr <= start_addr;
                        cnt      <= length;
                    end
                end else begin
                    pend <= fall | (pend & ~go);
                end
                if (fetch) begin
                    buffer   <= rom_data;
                    valid    <= 1'b1;
                    rom_addr <= rom_addr + AW'(1);
                end
                if (go) dout <= valid ? buffer : rom_data;
                if (state == WRITE && last) begin
                    valid <= 1'b0;
                    cnt   <= cnt - AW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_jt7759_host.sv
// tb_jt7759_host: directed scenarios with random memory latency, random cen_ctl and random memory content
module tb_jt7759_host;
    localparam int AW = 17;
    localparam int MASK = (1 << AW) - 1;

    logic          clk = 0, rstn = 1, cen_ctl = 0, start = 0, abort = 0, rom_ok = 0, drqn = 1;
    logic [AW-1:0] start_addr = '0, length = '0;
    logic [7:0]    rom_data = '0;
    logic          busy, done, rom_cs, cs, wrn;
    logic [AW-1:0] rom_addr;
    logic [7:0]    dout;

    jt7759_host #(.AW(AW), .WR_W(4)) dut (
        .clk(clk), .rstn(rstn), .cen_ctl(cen_ctl), .start(start), .start_addr(start_addr),
        .length(length), .abort(abort), .busy(busy), .done(done), .rom_cs(rom_cs),
        .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok), .drqn(drqn),
        .cs(cs), .wrn(wrn), .dout(dout)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int first; int last; int ticks; bit stable; logic [7:0] data;} strobe_t;
    logic [7:0] mem [0:MASK];
    strobe_t strobes[$];
    int ok_cyc[$], fetched[$], falls[$], done_cyc[$];
    bit done_busy[$], done_prev[$];
    int rom_cs_cycles = 0, errors = 0, checks = 0;
    bit slow = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge clk); #1 cen_ctl = 1'($urandom_range(0, 1));
    end

    // memory port: answers rom_cs after a random (or long) latency
    initial begin : mem_port
        int left;
        left = -1;
        forever begin
            @(posedge clk); #1;
            if (rom_ok) begin
                rom_ok = 0;
                left = -1;
            end else if (rom_cs) begin
                if (left < 0) left = slow ? 20 : int'($urandom_range(0, 3));
                if (left == 0) begin
                    rom_ok = 1;
                    rom_data = mem[rom_addr];
                    ok_cyc.push_back(cyc);
                    fetched.push_back(int'(rom_addr));
                end else left--;
            end else left = -1;
        end
    end

    initial begin : monitor
        bit in_str, prev_busy;
        strobe_t s;
        in_str = 0; prev_busy = 0;
        s = '{0, 0, 0, 1'b0, 8'h00};
        forever begin
            @(negedge clk);
            if (rom_cs === 1'b1) rom_cs_cycles++;
            if (done === 1'b1) begin
                done_cyc.push_back(cyc);
                done_busy.push_back(busy);
                done_prev.push_back(prev_busy);
            end
            if (cs === 1'b1) begin
                if (!in_str) begin
                    in_str = 1;
                    s = '{cyc, cyc, 0, 1'b1, dout};
                end
                if (dout !== s.data || wrn !== 1'b0) s.stable = 0;
                if (cen_ctl) s.ticks++;
                s.last = cyc;
            end else if (in_str) begin
                in_str = 0;
                strobes.push_back(s);
            end
            prev_busy = busy;
        end
    end

    task automatic clear_q();
        strobes.delete(); ok_cyc.delete(); fetched.delete(); falls.delete();
        done_cyc.delete(); done_busy.delete(); done_prev.delete();
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int a, input int l);
        @(posedge clk); #1 start = 1; start_addr = AW'(a); length = AW'(l);
        @(posedge clk); #1 start = 0;
    endtask

    task automatic fall_drqn();
        @(posedge clk); #1 drqn = 0;
        falls.push_back(cyc);
    endtask

    task automatic rise_drqn();
        @(posedge clk); #1 drqn = 1;
    endtask

    task automatic wait_cs(input string tag);
        int b = 0;
        while (cs !== 1'b1 && b < 100) begin @(posedge clk); #1; b++; end
        chk({tag, " cs wait"}, cs, 1);
    endtask

    task automatic wait_strobes(input int n, input string tag);
        int b = 0;
        while (strobes.size() < n && b < 300) begin @(posedge clk); #1; b++; end
        chk({tag, " strobe wait"}, 32'(strobes.size() >= n), 1);
    endtask

    task automatic wait_done(input string tag);
        int b = 0;
        while (done_cyc.size() < 1 && b < 100) begin @(posedge clk); #1; b++; end
        cycles(3);
        chk({tag, " done count"}, done_cyc.size(), 1);
    endtask

    task automatic check_stream(input string tag, input int base, input int len);
        int a;
        chk({tag, " strobes"}, strobes.size(), len);
        chk({tag, " fetches"}, fetched.size(), len);
        for (int i = 0; i < strobes.size() && i < len; i++) begin
            a = (base + i) & MASK;
            chk($sformatf("%s data%0d", tag, i), strobes[i].data, mem[a]);
            chk($sformatf("%s width%0d", tag, i), strobes[i].ticks, 4);
            chk($sformatf("%s stable%0d", tag, i), 32'(strobes[i].stable), 1);
            if (i < fetched.size()) chk($sformatf("%s addr%0d", tag, i), fetched[i], a);
        end
    endtask

    initial begin
        int t, b;
        for (int i = 0; i <= MASK; i++) mem[i] = 8'($urandom);
        mem[17'h100] = 8'hA0; mem[17'h101] = 8'hA1; mem[17'h102] = 8'hA2;
        #1 rstn = 0;
        @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst rom_cs", rom_cs, 0);
        chk("rst rom_addr", rom_addr, 0);
        chk("rst cs", cs, 0);
        chk("rst wrn", wrn, 1);
        chk("rst dout", dout, 0);
        @(posedge clk); #1 rstn = 1;
        cycles(2);

        // requests while idle must not be remembered
        fall_drqn(); cycles(2); rise_drqn(); cycles(2);
        clear_q();
        do_start(32'h100, 3);
        @(negedge clk);
        chk("basic busy", busy, 1);
        chk("basic rom_cs", rom_cs, 1);
        for (int i = 0; i < 3; i++) begin
            cycles(8);
            fall_drqn(); cycles(2); drqn = 1;
            wait_strobes(i + 1, "basic");
            if (strobes.size() > i) chk($sformatf("basic start%0d", i), strobes[i].first, falls[i] + 2);
        end
        wait_done("basic");
        if (done_cyc.size() > 0 && strobes.size() > 2) begin
            chk("basic done time", done_cyc[0], strobes[2].last + 2);
            chk("basic busy at done", 32'(done_busy[0]), 0);
            chk("basic busy before done", 32'(done_prev[0]), 1);
        end
        chk("basic rom_addr", rom_addr, 32'h103);
        check_stream("basic", 32'h100, 3);

        clear_q(); slow = 1;
        do_start(32'h200, 2);
        fall_drqn(); rise_drqn();
        wait_strobes(1, "slow");
        if (strobes.size() > 0 && ok_cyc.size() > 0) chk("slow start0", strobes[0].first, ok_cyc[0] + 1);
        cycles(2); fall_drqn(); rise_drqn();
        wait_strobes(2, "slow");
        if (strobes.size() > 1 && ok_cyc.size() > 1) chk("slow start1", strobes[1].first, ok_cyc[1] + 1);
        wait_done("slow");
        check_stream("slow", 32'h200, 2);
        slow = 0;

        clear_q(); rom_cs_cycles = 0;
        do_start(32'h300, 0);
        @(negedge clk);
        chk("zero done", done, 1);
        chk("zero busy", busy, 0);
        @(negedge clk);
        chk("zero done pulse", done, 0);
        cycles(5);
        chk("zero rom_cs", rom_cs_cycles, 0);
        chk("zero busy after", busy, 0);

        // second request lands while the first strobe is still out
        clear_q();
        do_start(32'h1FFFF, 2);
        cycles(8);
        fall_drqn();
        wait_cs("wrap");
        rise_drqn(); fall_drqn(); cycles(2); drqn = 1;
        wait_strobes(2, "wrap");
        wait_done("wrap");
        check_stream("wrap", 32'h1FFFF, 2);
        chk("wrap rom_addr", rom_addr, 1);

        clear_q();
        do_start(32'h300, 4);
        cycles(8);
        fall_drqn();
        t = 0; b = 0;
        while (t < 2 && b < 100) begin
            @(posedge clk); #2;
            if (cs && cen_ctl) t++;
            b++;
        end
        chk("abort tick wait", t, 2);
        abort = 1;
        @(posedge clk); #1 abort = 0; drqn = 1;
        @(negedge clk);
        chk("abort cs", cs, 0);
        chk("abort wrn", wrn, 1);
        chk("abort busy", busy, 0);
        chk("abort rom_cs", rom_cs, 0);
        cycles(10);
        chk("abort no done", done_cyc.size(), 0);
        chk("abort rom_addr", rom_addr, 32'h300 + fetched.size());
        clear_q();
        do_start(32'h400, 2);
        for (int i = 0; i < 2; i++) begin
            cycles(8);
            fall_drqn(); cycles(2); drqn = 1;
            wait_strobes(i + 1, "restart");
        end
        wait_done("restart");
        check_stream("restart", 32'h400, 2);

        // chip-like requester: re-arms 31 cen_ctl ticks after each strobe
        clear_q();
        do_start(32'h500, 16);
        cycles(10);
        for (int i = 0; i < 16; i++) begin
            fall_drqn();
            wait_cs("loop");
            rise_drqn();
            wait_strobes(i + 1, "loop");
            if (strobes.size() > i) chk($sformatf("loop nostall%0d", i), strobes[i].first, falls[i] + 2);
            t = 0; b = 0;
            while (t < 31 && b < 1000) begin
                @(negedge clk);
                if (cen_ctl) t++;
                b++;
            end
        end
        wait_done("loop");
        check_stream("loop", 32'h500, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
